// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int unsigned LANE_W    = 2;
  localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles little-endian bytes into 32-bit words and keeps the running frame XOR.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              xor_en,
  input  logic              byte_en,
  input  logic [7:0]        in_data,
  output logic [LANE_W-1:0] lane,
  output logic [7:0]        csum,
  output logic              word_valid,
  output logic [31:0]       word
);

  logic [23:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      lane       <= '0;
      csum       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shift <= '0;
        lane  <= '0;
        csum  <= '0;
      end else begin
        if (xor_en) csum <= csum ^ in_data;
        if (byte_en) begin
          shift <= {in_data, shift[23:8]};
          lane  <= lane + LANE_W'(1);
          // Fourth byte completes the word; lane wraps back to 0 by itself.
          if (lane == '1) begin
            word_valid <= 1'b1;
            word       <= {in_data, shift};
          end
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Frame parser and IMEM write driver; holds the core in reset until a verified image is loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);

  state_t            state, state_next;
  logic              accept;
  logic              rearm;
  logic              data_byte;
  logic              word_last;
  logic              hdr_bad;
  logic [7:0]        n_lo;
  logic [15:0]       n_full;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [31:0]       addr;
  logic [LANE_W-1:0] lane;
  logic [7:0]        csum;
  logic              word_valid;
  logic [31:0]       word;

  assign accept    = in_valid & in_ready;
  assign rearm     = restart & ((state == DONE) | (state == ERR));
  assign data_byte = accept & (state == DATA);
  assign n_full    = {in_data, n_lo};
  assign hdr_bad   = (n_full == 16'd0) | (32'(n_full) > DEPTH);
  assign word_last = (word_idx == last_idx) & (lane == '1);

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (rearm),
    .xor_en     (accept & (state inside {HDR_LO, HDR_HI, DATA})),
    .byte_en    (data_byte),
    .in_data    (in_data),
    .lane       (lane),
    .csum       (csum),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR_LO;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HDR_LO: if (accept) state_next = HDR_HI;
      HDR_HI: if (accept) state_next = hdr_bad ? ERR : DATA;
      DATA:   if (accept && word_last) state_next = CSUM;
      CSUM:   if (accept) state_next = (in_data == csum) ? DONE : ERR;
      DONE:   if (restart) state_next = HDR_LO;
      ERR:    if (restart) state_next = HDR_LO;
      default: state_next = HDR_LO;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      HDR_LO, HDR_HI, DATA, CSUM: in_ready = 1'b1;
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lo     <= '0;
      last_idx <= '0;
      word_idx <= '0;
      addr     <= BASE_ADDR;
    end else begin
      if (accept && state == HDR_LO) n_lo <= in_data;
      if (accept && state == HDR_HI) last_idx <= IDX_W'(n_full - 16'd1);
      if (rearm) begin
        word_idx <= '0;
        addr     <= BASE_ADDR;
      end else begin
        if (data_byte && lane == '1) word_idx <= word_idx + IDX_W'(1);
        // Address advances after the write cycle so it lines up with the registered word.
        if (word_valid) addr <= addr + 32'd4;
      end
    end
  end

  assign imem_we    = word_valid;
  assign imem_waddr = addr;
  assign imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed and random frames against a frame-level reference model.
module tb_imem_loader;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [7:0]  frame[$];
  logic [31:0] words[$];
  logic [31:0] got_addr[$], got_data[$];
  int unsigned got_cyc[$];
  logic [31:0] exp_addr[$], exp_data[$];
  bit          m_done, m_err;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_waddr);
      got_data.push_back(imem_wdata);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: interpret a byte frame directly from the frame rules.
  function automatic void model(input logic [7:0] f[$]);
    int unsigned n;
    logic [7:0]  x;
    exp_addr.delete();
    exp_data.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    n = 32'({f[1], f[0]});
    if (n == 0 || n > DEPTH) begin
      m_err = 1'b1;
      return;
    end
    x = '0;
    for (int i = 0; i < f.size() - 1; i++) x = x ^ f[i];
    for (int unsigned k = 0; k < n; k++) begin
      exp_addr.push_back(BASE_ADDR + 32'(4 * k));
      exp_data.push_back({f[4*k+5], f[4*k+4], f[4*k+3], f[4*k+2]});
    end
    m_done = (x == f[f.size()-1]);
    m_err  = !m_done;
  endfunction

  function automatic void build(input int unsigned n, input logic [7:0] flip);
    logic [7:0]  x;
    logic [15:0] n16;
    logic [31:0] w;
    n16 = 16'(n);
    frame.delete();
    frame.push_back(n16[7:0]);
    frame.push_back(n16[15:8]);
    if (n == 0 || n > DEPTH) return;
    for (int unsigned k = 0; k < n; k++) begin
      w = words[k];
      for (int unsigned j = 0; j < 4; j++) frame.push_back(w[8*j +: 8]);
    end
    x = '0;
    foreach (frame[i]) x = x ^ frame[i];
    frame.push_back(x ^ flip);
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned waited;
    waited = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int unsigned first, input int unsigned last, input bit gaps);
    for (int unsigned i = first; i <= last; i++) send_byte(frame[i], gaps);
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk({tag, "_waddr"}, got_addr[i], exp_addr[i]);
      chk({tag, "_wdata"}, got_data[i], exp_data[i]);
    end
  endtask

  task automatic check_end(input string tag, input bit exp_done, input bit exp_err);
    chk({tag, "_done"},  {31'd0, done},     {31'd0, exp_done});
    chk({tag, "_err"},   {31'd0, err},      {31'd0, exp_err});
    chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, imem_we},  32'd0);
  endtask

  task automatic do_restart(input bit with_byte);
    restart = 1'b1;
    if (with_byte) begin
      in_valid = 1'b1;
      in_data  = 8'hA5;
    end
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    chk("restart_ready", {31'd0, in_ready}, 32'd1);
    chk("restart_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("restart_done",  {31'd0, done},     32'd0);
    chk("restart_err",   {31'd0, err},      32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"},    {31'd0, imem_we},  32'd0);
    chk({tag, "_waddr"}, imem_waddr,        BASE_ADDR);
    chk({tag, "_wdata"}, imem_wdata,        32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, done},     32'd0);
    chk({tag, "_err"},   {31'd0, err},      32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    int unsigned n;
    logic [7:0]  flip;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int unsigned exp_writes;
  } vec_t;

  vec_t vecs[7];

  logic [31:0] prog[10] = '{32'h00500093, 32'h00000113, 32'h00208133, 32'hfff08093,
                            32'hfe009ce3, 32'h008000ef, 32'h0000006f, 32'h00110113,
                            32'h00008067, 32'h0000006f};
  logic [7:0]  case1[7] = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};

  initial begin
    vecs[0] = '{n: 1,     flip: 8'h00, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vecs[1] = '{n: 10,    flip: 8'h00, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 10};
    vecs[2] = '{n: 1,     flip: 8'h01, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 1};
    vecs[3] = '{n: 0,     flip: 8'h00, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[4] = '{n: 257,   flip: 8'h00, gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[5] = '{n: DEPTH, flip: 8'h00, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: DEPTH};
    vecs[6] = '{n: 37,    flip: 8'h5A, gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 37};

    #1;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed single-word frame with explicit write timing.
    frame.delete();
    foreach (case1[i]) frame.push_back(case1[i]);
    clear_got();
    send_range(0, 5, 1'b0);
    chk("c1_we_timing", {31'd0, imem_we}, 32'd1);
    chk("c1_waddr", imem_waddr, 32'h0);
    chk("c1_wdata", imem_wdata, 32'h00500093);
    send_range(6, 6, 1'b0);
    check_end("c1", 1'b1, 1'b0);
    do_restart(1'b0);

    // Ten-word program with random stalls.
    words.delete();
    foreach (prog[i]) words.push_back(prog[i]);
    build(10, 8'h00);
    model(frame);
    clear_got();
    send_range(0, 42, 1'b1);
    check_end("prog", m_done, m_err);
    check_writes("prog");
    do_restart(1'b0);

    // Bad checksum C3, then restart with a byte offered alongside it, then a good frame.
    frame.delete();
    foreach (case1[i]) frame.push_back(case1[i]);
    frame[6] = 8'hC3;
    clear_got();
    send_range(0, 6, 1'b0);
    check_end("badcs", 1'b0, 1'b1);
    chk("badcs_nwr", 32'(got_addr.size()), 32'd1);
    do_restart(1'b1);
    frame[6] = 8'hC2;
    clear_got();
    send_range(0, 6, 1'b0);
    check_end("afterrs", 1'b1, 1'b0);
    chk("afterrs_nwr", 32'(got_addr.size()), 32'd1);
    do_restart(1'b0);

    // Reset two bytes into word 3 of a five-word frame.
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    build(5, 8'h00);
    clear_got();
    send_range(0, 15, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    @(negedge clk);
    chk("midrst_nwr", 32'(got_addr.size()), 32'd3);
    rst_n = 1'b1;
    @(negedge clk);
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    build(3, 8'h00);
    model(frame);
    clear_got();
    send_range(0, 32'(frame.size() - 1), 1'b0);
    check_end("fresh", m_done, m_err);
    check_writes("fresh");
    do_restart(1'b0);

    // Table-driven random frames.
    for (int v = 0; v < 7; v++) begin
      words.delete();
      for (int unsigned k = 0; k < vecs[v].n && k < DEPTH; k++) words.push_back($urandom);
      build(vecs[v].n, vecs[v].flip);
      model(frame);
      clear_got();
      send_range(0, 32'(frame.size() - 1), vecs[v].gaps);
      check_end($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      chk($sformatf("vec%0d_model_done", v), {31'd0, done}, {31'd0, m_done});
      chk($sformatf("vec%0d_count", v), 32'(got_addr.size()), 32'(vecs[v].exp_writes));
      check_writes($sformatf("vec%0d", v));
      if (!vecs[v].gaps) begin
        for (int i = 1; i < got_cyc.size(); i++)
          chk($sformatf("vec%0d_spacing", v), got_cyc[i] - got_cyc[i-1], 32'd4);
      end
      do_restart(v[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and drives the instruction-memory write port at consecutive word addresses. It holds the core in reset until a complete, checksum-verified image has been written. It sits between the host link (UART or JTAG byte FIFO) and the IMEM write side; the core's fetch path reads the same array.

## Interface
- `DEPTH`, 256: IMEM capacity in 32-bit words; the maximum legal word count.
- `BASE_ADDR`, 32'h0: byte address of the first word written; must be word aligned.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid & in_ready`.
- `restart`  in  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- `imem_we`  out  1  IMEM write strobe, one cycle per word.
- `imem_waddr`  out  32  byte address of the write, always word aligned.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keeps the core in reset while high.
- `done`  out  1  image loaded and verified; sticky.
- `err`  out  1  bad header or checksum; sticky.

## Operation
- Frame format, in order:
  - `N[7:0]`, then `N[15:8]`.
  - 4·N payload bytes, each word sent LSB first.
  - One checksum byte equal to the XOR of every preceding frame byte (header and payload).
- States and transitions:
  - HDR_LO: latch `N[7:0]` and go to HDR_HI.
  - HDR_HI: latch `N[15:8]`. If N==0 or N>DEPTH, go to ERR. Otherwise go to DATA.
  - DATA: shift in bytes. On the 4th byte of each word, issue a write. After word N-1, go to CSUM.
  - CSUM: compare the received byte with the running XOR. Match goes to DONE; mismatch goes to ERR.
  - DONE and ERR: `restart` returns to HDR_LO. All other inputs are ignored.
- `in_ready` = 1 in HDR_LO, HDR_HI, DATA and CSUM; 0 in DONE and ERR. It is decoded from state only and never depends on `in_valid`.
- Word k is written to `BASE_ADDR + 4·k`, for k = 0..N-1.
- Byte j of a word (j = 0..3) lands in `wdata[8j+7:8j]`.
- The IMEM write always completes in one cycle, so there is no write backpressure.
- Running XOR and word index clear on entry to HDR_LO.
- Words already written before an ERR stay in IMEM and are not rolled back.
- `cpu_hold` = 1 in every state except DONE.
- `done` = 1 only in DONE; `err` = 1 only in ERR.
- Word index width is clog2(DEPTH+1). The word count field is 16 bits.

## Timing
- Reset values: state HDR_LO, `imem_we`=0, `imem_waddr`=`BASE_ADDR`, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0. `in_ready` reads 1 in this state.
- Reset asserted mid-frame aborts the frame immediately. The partially assembled word is discarded and no write is issued.
- Write latency: `imem_we` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `imem_waddr` and `imem_wdata` are registered and valid in that same cycle.
- Back-to-back bytes are accepted every cycle with no bubbles, including across word boundaries and into CSUM.
- `in_valid` low stalls the loader with no timeout. Partial state is held indefinitely.
- DONE/ERR entry: `done` (or `err`) rises and `cpu_hold` falls the cycle after the checksum byte is accepted. On an ERR, `cpu_hold` stays high.
- The last write and the `done` rise occur in different cycles: the write comes at least one cycle before `done`.
- Bad header: `err` rises the cycle after the `N[15:8]` byte is accepted.
- `restart` in DONE or ERR: the next cycle has state HDR_LO, `cpu_hold`=1, `done`=`err`=0 and `in_ready`=1.
- `restart` in any other state has no effect. A byte presented together with `restart` in DONE/ERR is not consumed, because `in_ready`=0 that cycle.

## Structure
- `imem_loader_pkg` holds:
  - The state enum: HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR.
  - The byte-lane index width (2).
  - Constant `HDR_BYTES`=2.
- Sub-module `imem_byte_packer` contains:
  - the 4-byte shift register and lane counter;
  - the running XOR;
  - a registered `word_valid` pulse together with the word.
- The top level owns the FSM, word counter and address register, and the output flops.

## Test plan
- N=1, bytes 01 00 93 00 50 00 C2 → one write with `waddr`=0x0, `wdata`=0x00500093; then `done`=1 and `cpu_hold`=0.
- N=10 from the branch/subroutine test program, streamed with random `in_valid` gaps → 10 writes at 0x00..0x24 with the correct words in order; `done`=1.
- N=1 with the checksum byte C3 instead of C2 → the write still occurs; `err`=1, `done`=0, `cpu_hold`=1. Then `restart` followed by a valid frame → `done`=1.
- Header 00 00 (N=0) → `err`=1 one cycle after the 2nd byte, no writes. Header 01 01 (N=257) with DEPTH=256 → same result.
- Reset asserted after 2 of 4 bytes of word 3 of a 5-word frame → no write for word 3. All outputs return to their reset values. A fresh frame loads correctly from 0x0.
- N=DEPTH, bytes back-to-back with `in_valid` held high → one write every 4 cycles; last `waddr` = `BASE_ADDR`+0x3FC; `done`=1.
